// File: rtl/discr_scaler_readout.sv
// Purpose: generic single-clock FIFO with a registered read port and drop reporting.
// Latency: a pushed word is visible one clock later; a popped word appears one clock after the pop.
// Backpressure: a push while full is refused (push_drop) unless a pop is accepted in the same cycle.
// Ports: push_vld/push_dat write side; pop_req/pop_dat/pop_vld read side; empty/full status.
module discr_scaler_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_req,
  output logic [W-1:0] pop_dat,
  output logic         pop_vld,
  output logic         empty,
  output logic         full,
  output logic         push_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          pop_ok;
  logic          push_ok;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign pop_ok    = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_vld & (~full | pop_ok);
  assign push_drop = push_vld & full & ~pop_ok;

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      pop_dat <= '0;
      pop_vld <= 1'b0;
    end else begin
      pop_vld <= pop_ok;
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok) begin
        rptr    <= rptr + AW'(1);
        pop_dat <= mem[rptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Purpose: sums the scaler's per-cycle edge counts per period and queues tagged records for readout.
// Latency: record visible one clock after update_in; rd_data/rd_valid one clock after an accepted rd_req.
// Backpressure: none upstream; records arriving at a full FIFO are dropped and counted in drop_cnt.
// Ports: valid/n_pedge_in/update_in from the scaler; rd_req/rd_data/rd_valid readout;
//        fifo_empty/fifo_full/drop_cnt status.
module discr_scaler_readout #(
  parameter int P_N_WIDTH   = 4,
  parameter int P_CNT_WIDTH = 16,
  parameter int P_DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  input  logic [P_N_WIDTH-1:0]   n_pedge_in,
  input  logic                   update_in,
  input  logic                   rd_req,
  output logic [P_CNT_WIDTH+9:0] rd_data,
  output logic                   rd_valid,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [15:0]            drop_cnt
);
  typedef struct packed {
    logic [7:0]             seq;
    logic                   inv;
    logic                   sat;
    logic [P_CNT_WIDTH-1:0] count;
  } rec_t;

  logic [P_CNT_WIDTH-1:0] acc;
  logic [7:0]             seq;
  logic                   sat_r;
  logic                   inv_r;
  logic [P_N_WIDTH-1:0]   n_eff;
  logic [P_CNT_WIDTH:0]   sum;
  logic                   ovf;
  logic [P_CNT_WIDTH-1:0] acc_nxt;
  rec_t                   rec;
  logic                   push_drop;

  assign n_eff   = valid ? n_pedge_in : '0;
  // One extra bit on the sum exposes the carry used for saturation.
  assign sum     = {1'b0, acc} + {{(P_CNT_WIDTH + 1 - P_N_WIDTH){1'b0}}, n_eff};
  assign ovf     = sum[P_CNT_WIDTH];
  assign acc_nxt = ovf ? '1 : sum[P_CNT_WIDTH-1:0];

  // The closing cycle's count and flags belong to the period being closed.
  always_comb begin
    rec       = '0;
    rec.seq   = seq;
    rec.inv   = inv_r | ~valid;
    rec.sat   = sat_r | ovf;
    rec.count = acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      seq      <= '0;
      sat_r    <= 1'b0;
      inv_r    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (update_in) begin
        acc   <= '0;
        sat_r <= 1'b0;
        inv_r <= 1'b0;
        // Advances even on a dropped record so the reader can detect gaps.
        seq   <= seq + 8'd1;
      end else begin
        acc   <= acc_nxt;
        sat_r <= sat_r | ovf;
        inv_r <= inv_r | ~valid;
      end
      if (push_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  discr_scaler_fifo #(
    .W     ($bits(rec_t)),
    .DEPTH (P_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_vld  (update_in),
    .push_dat  (rec),
    .pop_req   (rd_req),
    .pop_dat   (rd_data),
    .pop_vld   (rd_valid),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .push_drop (push_drop)
  );
endmodule

// File: tb/tb_discr_scaler_readout.sv
// Directed bench for discr_scaler_readout with P_N_WIDTH=4, P_CNT_WIDTH=8, P_DEPTH=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_discr_scaler_readout;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  n_pedge_in;
  logic        update_in;
  logic        rd_req;
  logic [17:0] rd_data;
  logic        rd_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  discr_scaler_readout #(
    .P_N_WIDTH   (4),
    .P_CNT_WIDTH (8),
    .P_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .n_pedge_in (n_pedge_in),
    .update_in  (update_in),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] rec(input int s, input bit inv, input bit sat, input int cnt);
    logic [7:0] s8;
    logic [7:0] c8;
    s8 = s[7:0];
    c8 = cnt[7:0];
    return {s8, inv, sat, c8};
  endfunction

  task automatic idle();
    valid      = 1'b1;
    n_pedge_in = 4'd0;
    update_in  = 1'b0;
    rd_req     = 1'b0;
  endtask

  // Drives one period of 'cycles' cycles with count n; cycle index 'bad' has valid low.
  task automatic run_period(input int n, input int cycles, input int bad);
    for (int i = 0; i < cycles; i++) begin
      valid      = (i != bad);
      n_pedge_in = n[3:0];
      update_in  = (i == cycles - 1);
      step();
    end
    idle();
  endtask

  task automatic pop_check(input string tag, input logic [17:0] exp);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check({tag, ".vld"}, 32'(rd_valid), 32'd1);
    check({tag, ".dat"}, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_rdvld", 32'(rd_valid), 32'd0);
    check("rst_rddat", 32'(rd_data), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1. basic period, then the same stimulus again
    run_period(4, 3, -1);
    check("t1_notempty", 32'(fifo_empty), 32'd0);
    pop_check("t1_rec0", rec(0, 0, 0, 12));
    step();
    check("t1_vld_pulse", 32'(rd_valid), 32'd0);
    check("t1_hold", 32'(rd_data), 32'(rec(0, 0, 0, 12)));
    check("t1_empty", 32'(fifo_empty), 32'd1);
    run_period(4, 3, -1);
    pop_check("t1_rec1", rec(1, 0, 0, 12));

    // 2. saturation, then a clean period
    run_period(15, 20, -1);
    pop_check("t2_sat", rec(2, 0, 1, 255));
    run_period(1, 2, -1);
    pop_check("t2_clear", rec(3, 0, 0, 2));

    // 3. one invalid cycle
    run_period(5, 4, 1);
    pop_check("t3_inv", rec(4, 1, 0, 15));

    // 4. overflow from fresh reset
    do_reset();
    for (int k = 0; k < 6; k++) run_period(1, 1, -1);
    check("t4_full", 32'(fifo_full), 32'd1);
    check("t4_drop", 32'(drop_cnt), 32'd2);
    pop_check("t4_pop0", rec(0, 0, 0, 1));
    pop_check("t4_pop1", rec(1, 0, 0, 1));
    pop_check("t4_pop2", rec(2, 0, 0, 1));
    pop_check("t4_pop3", rec(3, 0, 0, 1));
    check("t4_empty", 32'(fifo_empty), 32'd1);
    run_period(2, 1, -1);
    pop_check("t4_gap", rec(6, 0, 0, 2));

    // 5a. full FIFO, push and pop together
    for (int k = 0; k < 4; k++) run_period(1, 1, -1);
    check("t5_full_pre", 32'(fifo_full), 32'd1);
    valid      = 1'b1;
    n_pedge_in = 4'd1;
    update_in  = 1'b1;
    rd_req     = 1'b1;
    step();
    idle();
    check("t5_full_vld", 32'(rd_valid), 32'd1);
    check("t5_full_dat", 32'(rd_data), 32'(rec(7, 0, 0, 1)));
    check("t5_full_stay", 32'(fifo_full), 32'd1);
    check("t5_full_drop", 32'(drop_cnt), 32'd2);
    pop_check("t5_drain8", rec(8, 0, 0, 1));
    pop_check("t5_drain9", rec(9, 0, 0, 1));
    pop_check("t5_drain10", rec(10, 0, 0, 1));
    pop_check("t5_drain11", rec(11, 0, 0, 1));
    check("t5_drained", 32'(fifo_empty), 32'd1);

    // 5b. empty FIFO, push and pop together
    valid      = 1'b1;
    n_pedge_in = 4'd3;
    update_in  = 1'b1;
    rd_req     = 1'b1;
    step();
    idle();
    check("t5_empty_vld", 32'(rd_valid), 32'd0);
    check("t5_empty_flag", 32'(fifo_empty), 32'd0);
    pop_check("t5_empty_rec", rec(12, 0, 0, 3));

    // 6. asynchronous reset mid-period with records queued
    run_period(1, 1, -1);
    run_period(1, 1, -1);
    valid      = 1'b1;
    n_pedge_in = 4'd2;
    rd_req     = 1'b1;
    step();
    rd_req = 1'b0;
    check("t6_pre_vld", 32'(rd_valid), 32'd1);
    check("t6_pre_drop", 32'(drop_cnt), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_empty", 32'(fifo_empty), 32'd1);
    check("t6_drop", 32'(drop_cnt), 32'd0);
    check("t6_vld", 32'(rd_valid), 32'd0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    run_period(3, 2, -1);
    pop_check("t6_after", rec(0, 0, 0, 6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
